// File: rtl/qcldpc_pkg.sv
// Shared QC-LDPC definitions: code geometry, lifting sizes, proto-matrix shift table
// and helpers used by both the encoder and the syndrome checker.
package qcldpc_pkg;

  localparam int unsigned CFG_NUM_Z         = 3;
  localparam int unsigned CFG_MAX_Z         = 81;
  localparam int unsigned CFG_NUM_INFO_BLKS = 20;
  localparam int unsigned CFG_NUM_PAR_BLKS  = 4;
  localparam int unsigned CFG_TOTAL_BLKS    = CFG_NUM_INFO_BLKS + CFG_NUM_PAR_BLKS;
  localparam int unsigned CFG_SHIFT_W       = $clog2(CFG_MAX_Z);
  localparam int unsigned CFG_ZI_W          = $clog2(CFG_NUM_Z);

  localparam int unsigned Z_VALUES_DEF [CFG_NUM_Z] = '{27, 54, 81};

  localparam logic [CFG_SHIFT_W-1:0] SHIFT_NULL = '1;

  typedef logic [CFG_NUM_Z-1:0][CFG_NUM_PAR_BLKS-1:0][CFG_TOTAL_BLKS-1:0][CFG_SHIFT_W-1:0] shift_tab_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_REPORT
  } chk_state_e;

  // Base shifts are defined at Z=81 and floor-scaled to each lifting size; the
  // parity part is a diagonal of identity circulants so parity row j solves p_j.
  function automatic shift_tab_t build_shifts();
    shift_tab_t  t;
    int unsigned base;
    t = '0;
    for (int unsigned zi = 0; zi < CFG_NUM_Z; zi++) begin
      for (int unsigned r = 0; r < CFG_NUM_PAR_BLKS; r++) begin
        for (int unsigned c = 0; c < CFG_TOTAL_BLKS; c++) begin
          if (c >= CFG_NUM_INFO_BLKS) begin
            t[zi][r][c] = (c - CFG_NUM_INFO_BLKS == r) ? '0 : SHIFT_NULL;
          end else if ((c + r) % 5 == 3) begin
            t[zi][r][c] = SHIFT_NULL;
          end else begin
            base = (37 * r + 11 * c + 5) % CFG_MAX_Z;
            t[zi][r][c] = CFG_SHIFT_W'(base * Z_VALUES_DEF[zi] / CFG_MAX_Z);
          end
        end
      end
    end
    return t;
  endfunction

  localparam shift_tab_t PROTO_SHIFTS = build_shifts();

  function automatic logic [CFG_ZI_W-1:0] onehot_to_idx(input logic [CFG_NUM_Z-1:0] oh);
    logic [CFG_ZI_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < CFG_NUM_Z; i++) begin
      if (oh[i]) idx = CFG_ZI_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/qcldpc_proto_rom.sv
// Asynchronous-read proto-matrix ROM: returns the circulant shift of every parity
// row for one lifting size and one code column.
module qcldpc_proto_rom
  import qcldpc_pkg::*;
#(
  parameter int unsigned NUM_Z        = CFG_NUM_Z,
  parameter int unsigned NUM_PAR_BLKS = CFG_NUM_PAR_BLKS,
  parameter int unsigned TOTAL_BLKS   = CFG_TOTAL_BLKS,
  parameter int unsigned SHIFT_W      = CFG_SHIFT_W
) (
  input  logic [$clog2(NUM_Z)-1:0]        z_idx,
  input  logic [$clog2(TOTAL_BLKS)-1:0]   col,
  output logic [NUM_PAR_BLKS*SHIFT_W-1:0] shifts
);

  always_comb begin
    shifts = '0;
    for (int unsigned r = 0; r < NUM_PAR_BLKS; r++) begin
      shifts[r*SHIFT_W +: SHIFT_W] = PROTO_SHIFTS[z_idx][r][col];
    end
  end

endmodule

// File: rtl/qcldpc_syndrome_checker.sv
// Hard-decision QC-LDPC syndrome check: folds each received sub-block into the
// per-row circulant accumulators and reports whether every parity row is zero.
module qcldpc_syndrome_checker
  import qcldpc_pkg::*;
#(
  parameter int unsigned NUM_Z              = CFG_NUM_Z,
  parameter int unsigned MAX_Z              = CFG_MAX_Z,
  parameter int unsigned NUM_INFO_BLKS      = CFG_NUM_INFO_BLKS,
  parameter int unsigned NUM_PAR_BLKS       = CFG_NUM_PAR_BLKS,
  parameter int unsigned TOTAL_BLKS         = NUM_INFO_BLKS + NUM_PAR_BLKS,
  parameter int unsigned Z_VALUES [NUM_Z]   = Z_VALUES_DEF,
  parameter int unsigned SHIFT_W            = $clog2(MAX_Z)
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic [NUM_Z-1:0]        req_z,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MAX_Z-1:0]        in_blk,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    syn_ok,
  output logic [NUM_PAR_BLKS-1:0] syn_mask,
  output logic                    cfg_err
);

  localparam int unsigned ZI_W  = $clog2(NUM_Z);
  localparam int unsigned COL_W = $clog2(TOTAL_BLKS);

  chk_state_e state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d, cur_col;
  logic [ZI_W-1:0]   zidx_q, cur_zidx;
  logic              err_q, cur_err, req_ok;
  logic              live_q, first, accept, last;
  logic [SHIFT_W-1:0] zval, s;
  logic [MAX_Z-1:0]  zmask;
  logic [MAX_Z-1:0]  acc_q [NUM_PAR_BLKS];
  logic [MAX_Z-1:0]  acc_d [NUM_PAR_BLKS];
  logic [NUM_PAR_BLKS-1:0] mask_d, syn_mask_q;
  logic              syn_ok_q, cfg_err_q;
  logic [NUM_PAR_BLKS*SHIFT_W-1:0] shifts;

  // Rotation by s<z inside a z-bit window: bits pushed past z wrap back via t>>z.
  function automatic logic [MAX_Z-1:0] rotl_z(input logic [MAX_Z-1:0]   x,
                                               input logic [SHIFT_W-1:0] sh,
                                               input logic [SHIFT_W-1:0] z,
                                               input logic [MAX_Z-1:0]   m);
    logic [2*MAX_Z-1:0] t;
    t = {{MAX_Z{1'b0}}, x & m} << sh;
    return (t[MAX_Z-1:0] | MAX_Z'(t >> z)) & m;
  endfunction

  assign first    = (state_q == ST_IDLE);
  assign in_ready = live_q & ~rst & (state_q != ST_REPORT);
  assign accept   = in_valid & in_ready;
  assign req_ok   = (req_z != '0) && ((req_z & (req_z - 1'b1)) == '0);
  assign cur_zidx = first ? (req_ok ? onehot_to_idx(req_z) : '0) : zidx_q;
  assign cur_err  = first ? ~req_ok : err_q;
  assign cur_col  = first ? '0 : col_q;
  assign last     = (cur_col == COL_W'(TOTAL_BLKS - 1));
  assign zval     = SHIFT_W'(Z_VALUES[cur_zidx]);
  assign zmask    = (MAX_Z'(1) << zval) - MAX_Z'(1);

  qcldpc_proto_rom #(
    .NUM_Z       (NUM_Z),
    .NUM_PAR_BLKS(NUM_PAR_BLKS),
    .TOTAL_BLKS  (TOTAL_BLKS),
    .SHIFT_W     (SHIFT_W)
  ) u_rom (
    .z_idx (cur_zidx),
    .col   (cur_col),
    .shifts(shifts)
  );

  // Beat 0 folds into a cleared accumulator instead of the stale previous block.
  always_comb begin
    s = '0;
    for (int unsigned r = 0; r < NUM_PAR_BLKS; r++) begin
      acc_d[r] = acc_q[r];
      if (accept) begin
        s        = shifts[r*SHIFT_W +: SHIFT_W];
        acc_d[r] = first ? '0 : acc_q[r];
        if (s != SHIFT_NULL) acc_d[r] = acc_d[r] ^ rotl_z(in_blk, s, zval, zmask);
      end
      mask_d[r] = |acc_d[r];
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          col_d   = last ? '0 : cur_col + COL_W'(1);
          state_d = last ? ST_REPORT : ST_ACCUM;
        end
      end
      ST_REPORT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      zidx_q     <= '0;
      err_q      <= 1'b0;
      live_q     <= 1'b0;
      syn_mask_q <= '0;
      syn_ok_q   <= 1'b0;
      cfg_err_q  <= 1'b0;
      for (int unsigned r = 0; r < NUM_PAR_BLKS; r++) acc_q[r] <= '0;
    end else begin
      live_q  <= 1'b1;
      state_q <= state_d;
      col_q   <= col_d;
      for (int unsigned r = 0; r < NUM_PAR_BLKS; r++) acc_q[r] <= acc_d[r];
      if (accept && first) begin
        zidx_q <= cur_zidx;
        err_q  <= cur_err;
      end
      if (accept && last) begin
        syn_mask_q <= mask_d;
        syn_ok_q   <= ~|mask_d & ~cur_err;
        cfg_err_q  <= cur_err;
      end
    end
  end

  assign out_valid = (state_q == ST_REPORT);
  assign syn_ok    = syn_ok_q;
  assign syn_mask  = syn_mask_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_qcldpc_syndrome_checker.sv
// Directed bench for qcldpc_syndrome_checker with a small reference encoder.
module tb_qcldpc_syndrome_checker;
  import qcldpc_pkg::*;

  localparam int unsigned TB = 24;
  localparam int unsigned MZ = 81;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    req_z = 3'b001;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MZ-1:0] in_blk = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          syn_ok;
  logic [3:0]    syn_mask;
  logic          cfg_err;

  int total = 0;
  int bad   = 0;

  logic [MZ-1:0] blk [TB];
  logic [MZ-1:0] saved [TB];

  always #5 CLK = ~CLK;

  qcldpc_syndrome_checker dut (
    .CLK      (CLK),
    .rst      (rst),
    .req_z    (req_z),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_blk   (in_blk),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .syn_ok   (syn_ok),
    .syn_mask (syn_mask),
    .cfg_err  (cfg_err)
  );

  initial begin
    for (int zi = 0; zi < 3; zi++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < TB; c++)
          assert (PROTO_SHIFTS[zi][r][c] == SHIFT_NULL || int'(PROTO_SHIFTS[zi][r][c]) < int'(Z_VALUES_DEF[zi]))
            else $error("shift out of range z=%0d r=%0d c=%0d", zi, r, c);
  end

  function automatic logic [MZ-1:0] brot(input logic [MZ-1:0] x, input int s, input int z);
    logic [MZ-1:0] y = '0;
    for (int i = 0; i < z; i++) y[(i + s) % z] = x[i];
    return y;
  endfunction

  function automatic logic [MZ-1:0] rnd_z(input int z);
    logic [MZ-1:0] v;
    v = {$urandom, $urandom, $urandom};
    for (int i = z; i < MZ; i++) v[i] = 1'b0;
    return v;
  endfunction

  task automatic make_codeword(input int zi);
    logic [MZ-1:0] p;
    int z;
    z = int'(Z_VALUES_DEF[zi]);
    for (int c = 0; c < 20; c++) blk[c] = rnd_z(z);
    for (int j = 0; j < 4; j++) begin
      p = '0;
      for (int c = 0; c < 20; c++)
        if (PROTO_SHIFTS[zi][j][c] != SHIFT_NULL) p = p ^ brot(blk[c], int'(PROTO_SHIFTS[zi][j][c]), z);
      blk[20 + j] = p;
    end
  endtask

  task automatic drive_beat(input logic [MZ-1:0] b);
    bit took = 0;
    in_valid = 1'b1;
    in_blk   = b;
    for (int k = 0; k < 50 && !took; k++) begin
      @(negedge CLK);
      took = in_ready;
      @(posedge CLK); #1;
    end
    if (!took) begin
      total++; bad++;
      $display("FAIL beat_accept: in_ready stuck at 0, required 1");
    end
  endtask

  task automatic send_block(input logic [2:0] z, input int bubble_pct);
    req_z = z;
    for (int i = 0; i < TB; i++) begin
      if (bubble_pct != 0 && int'($urandom_range(99)) < bubble_pct) begin
        in_valid = 1'b0;
        @(posedge CLK); #1;
      end
      drive_beat(blk[i]);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name);
    for (int k = 0; k < 100 && !out_valid; k++) @(negedge CLK);
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout: out_valid=%b required 1", name, out_valid);
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string name, input logic ok, input logic [3:0] mask, input logic err);
    total++;
    if (syn_ok !== ok) begin bad++; $display("FAIL %s_ok: got %b want %b", name, syn_ok, ok); end
    total++;
    if (syn_mask !== mask) begin bad++; $display("FAIL %s_mask: got %b want %b", name, syn_mask, mask); end
    total++;
    if (cfg_err !== err) begin bad++; $display("FAIL %s_err: got %b want %b", name, cfg_err, err); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total++;
    if ({in_ready, out_valid, syn_ok, syn_mask, cfg_err} !== 8'b0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b ov=%b ok=%b mask=%b err=%b want all 0",
               in_ready, out_valid, syn_ok, syn_mask, cfg_err);
    end
    @(posedge CLK); #1;
    rst = 1'b0;
    @(posedge CLK); #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_zero_block();
    req_z = 3'b001;
    for (int i = 0; i < TB - 1; i++) drive_beat('0);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL zero_early_valid: got %b want 0", out_valid); end
    drive_beat('0);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL zero_valid_latency: got %b want 1", out_valid); end
    check_result("zero", 1'b1, 4'b0000, 1'b0);
    release_result();
  endtask

  task automatic test_single_bit();
    for (int i = 0; i < TB; i++) blk[i] = '0;
    blk[0][0] = 1'b1;
    send_block(3'b001, 0);
    wait_result("bit0");
    check_result("bit0", 1'b0, 4'b0111, 1'b0);
    release_result();
  endtask

  task automatic test_codeword_z81();
    int fcol [3] = '{5, 7, 22};
    int fbit [3] = '{80, 13, 40};
    logic [3:0] fmask [3] = '{4'b0111, 4'b1101, 4'b0100};
    make_codeword(2);
    send_block(3'b100, 30);
    wait_result("cw81");
    check_result("cw81", 1'b1, 4'b0000, 1'b0);
    release_result();
    for (int i = 0; i < TB; i++) saved[i] = blk[i];
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < TB; i++) blk[i] = saved[i];
      blk[fcol[f]][fbit[f]] = ~blk[fcol[f]][fbit[f]];
      send_block(3'b100, 20);
      wait_result("cw81_flip");
      check_result("cw81_flip", 1'b0, fmask[f], 1'b0);
      release_result();
    end
  endtask

  task automatic test_upper_ignored();
    make_codeword(0);
    for (int i = 0; i < TB; i++) blk[i][MZ-1:27] = '1;
    send_block(3'b001, 0);
    wait_result("upper");
    check_result("upper", 1'b1, 4'b0000, 1'b0);
    release_result();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < TB; i++) blk[i] = '0;
    send_block(3'b010, 0);
    in_valid = 1'b1;
    in_blk   = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || syn_ok !== 1'b1 || syn_mask !== 4'b0) begin
        bad++;
        $display("FAIL hold_stable: ov=%b rdy=%b ok=%b mask=%b want 1 0 1 0000",
                 out_valid, in_ready, syn_ok, syn_mask);
      end
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    release_result();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_release: rdy=%b ov=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_cfg_err();
    for (int i = 0; i < TB; i++) blk[i] = '0;
    req_z = 3'b011;
    for (int i = 0; i < TB - 1; i++) drive_beat(blk[i]);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL cfg_early_valid: got %b want 0", out_valid); end
    drive_beat(blk[TB-1]);
    in_valid = 1'b0;
    wait_result("cfg");
    check_result("cfg", 1'b0, 4'b0000, 1'b1);
    release_result();
  endtask

  task automatic test_reset_midblock();
    req_z = 3'b010;
    for (int i = 0; i < 10; i++) drive_beat(rnd_z(54) | 81'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge CLK);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %b want 0", in_ready); end
    @(posedge CLK); #1;
    rst = 1'b0;
    make_codeword(1);
    send_block(3'b010, 25);
    wait_result("midrst");
    check_result("midrst", 1'b1, 4'b0000, 1'b0);
    release_result();
  endtask

  initial begin
    test_reset();
    test_zero_block();
    test_single_bit();
    test_codeword_z81();
    test_upper_ignored();
    test_backpressure();
    test_cfg_err();
    test_reset_midblock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
